// File: rtl/nn_result_collector.sv
// nn_result_collector
//   Receiving end of the NN_top result interface. Each new valid period on
//   nn_data_v produces exactly one capture of nn_data. A capture goes into a
//   small show-ahead FIFO for a ready/valid reader. Every capture also updates
//   the running statistics: result count, dropped count, and signed min/max.
//
// Ports
//   clk_in      : system clock, rising edge
//   rst_n       : asynchronous reset, active HIGH (legacy name)
//   nn_data     : signed NN result
//   nn_data_v   : level valid, held high while the result is held
//   clear       : synchronous clear of the FIFO and all statistics
//   rd_data     : FIFO head (show-ahead), 0 while rd_valid is low
//   rd_valid    : FIFO not empty
//   rd_ready    : reader accepts the head when rd_valid & rd_ready
//   result_cnt  : saturating count of captures (kept or dropped)
//   drop_cnt    : saturating count of captures lost to a full FIFO
//   min_val     : signed minimum of the captured results
//   max_val     : signed maximum of the captured results
//   stats_valid : at least one capture since reset/clear
module nn_result_collector #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] nn_data,
    input  logic              nn_data_v,
    input  logic              clear,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  result_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic              stats_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_WAIT_LOW,
        S_ARMED,
        S_HELD
    } state_t;

    state_t              state_q, state_d;
    logic                capture;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0]    rcnt_q, rcnt_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic                sv_q, sv_d;

    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    // Capture FSM: one capture per high period of nn_data_v, and none for a
    // valid that is already high when reset is released.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_WAIT_LOW: if (!nn_data_v) state_d = S_ARMED;
            S_ARMED: begin
                if (nn_data_v) begin
                    capture = 1'b1;
                    state_d = S_HELD;
                end
            end
            S_HELD:     if (!nn_data_v) state_d = S_ARMED;
            default:    state_d = S_WAIT_LOW;
        endcase
    end

    assign rd_valid = (occ_q != '0);
    assign full     = (occ_q == OCC_W'(DEPTH));
    assign pop      = rd_valid & rd_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign push     = capture & ~clear & (~full | pop);
    assign drop     = capture & ~clear & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        rcnt_d   = rcnt_q;
        dcnt_d   = dcnt_q;
        min_d    = min_q;
        max_d    = max_q;
        sv_d     = sv_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            rcnt_d   = '0;
            dcnt_d   = '0;
            min_d    = '0;
            max_d    = '0;
            sv_d     = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      occ_d = occ_q + OCC_W'(1);
            else if (!push && pop) occ_d = occ_q - OCC_W'(1);
            if (capture) begin
                if (rcnt_q != '1) rcnt_d = rcnt_q + CNT_W'(1);
                if (!sv_q) begin
                    min_d = nn_data;
                    max_d = nn_data;
                    sv_d  = 1'b1;
                end else begin
                    if ($signed(nn_data) < $signed(min_q)) min_d = nn_data;
                    if ($signed(nn_data) > $signed(max_q)) max_d = nn_data;
                end
            end
            if (drop && dcnt_q != '1) dcnt_d = dcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= S_WAIT_LOW;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            rcnt_q   <= '0;
            dcnt_q   <= '0;
            min_q    <= '0;
            max_q    <= '0;
            sv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rcnt_q   <= rcnt_d;
            dcnt_q   <= dcnt_d;
            min_q    <= min_d;
            max_q    <= max_d;
            sv_q     <= sv_d;
        end
    end

    // Storage needs no reset: entries are only visible through occ_q.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= nn_data;
    end

    assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign result_cnt  = rcnt_q;
    assign drop_cnt    = dcnt_q;
    assign min_val     = min_q;
    assign max_val     = max_q;
    assign stats_valid = sv_q;

endmodule
